spi_slave_stream: RTL and testbench

SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

---
 rtl/spi_slave_stream.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_slave_stream.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_stream.sv
// rtl/spi_slave_stream.sv - SPI slave with streaming tx/rx word handshakes
//
// Purpose: SPI slave with all four modes and either bit order. Received words
// are handed to a valid/ready consumer. Transmit words come from a valid/ready
// producer through a one-word holding register. A frame may carry any number
// of consecutive words.
//
// Optional feature: define SPI_SLAVE_STREAM_STATUS_EN to build the sticky
// tx_underrun / rx_overrun flags. Without it both outputs are tied to 0.
//
// Ports:
//   clock, reset           system clock (rising edge), async active-high reset
//   cpol, cpha, lsb_first  SPI mode and bit order, latched when a frame starts
//   tx_data/valid/ready    transmit word handshake (tx_ready = holding reg empty)
//   rx_data/valid/ready    received word handshake
//   frame_active           high while a frame is in progress
//   tx_underrun/rx_overrun sticky status, cleared when the next frame starts
//   sclk, ce, mosi         asynchronous SPI pins
//   miso, miso_oe          serial data out and its output enable
module spi_slave_stream #(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    CE_LEVEL   = 1'b0,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_active,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
  input  logic                  sclk,
  input  logic                  ce,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe
);

  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic ce_s1, ce_s2, ce_s3;
  logic mosi_s1, mosi_s2;
  logic [1:0] sync_fill;
  logic armed;

  state_t state, state_next;
  logic   frame_start;

  logic cpol_l, cpha_l, lsb_l;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_sr, rx_next;
  logic [DATA_WIDTH-1:0] tx_sr, hold_data;
  logic                  hold_full;

  // Two-flop synchronizers; the third stage only serves edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      ce_s1   <= ~CE_LEVEL;
      ce_s2   <= ~CE_LEVEL;
      ce_s3   <= ~CE_LEVEL;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      ce_s1   <= ce;
      ce_s2   <= ce_s1;
      ce_s3   <= ce_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  logic ce_on, ce_on_d;
  assign ce_on   = (ce_s2 == CE_LEVEL);
  assign ce_on_d = (ce_s3 == CE_LEVEL);

  // The synchronizers reset to "CE inactive", so a CE already asserted at
  // reset release would look like an edge. Frames are only accepted once the
  // pipeline holds real pin samples and CE has been seen inactive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && !ce_on)
        armed <= 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (armed && ce_on && !ce_on_d) state_next = S_ACTIVE;
      S_ACTIVE: if (!ce_on)                     state_next = S_IDLE;
      default:                                  state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    frame_active = (state == S_ACTIVE);
    frame_start  = (state == S_IDLE) && (state_next == S_ACTIVE);
  end

  assign miso_oe = frame_active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
      lsb_l  <= 1'b0;
    end else if (frame_start) begin
      cpol_l <= cpol;
      cpha_l <= cpha;
      lsb_l  <= lsb_first;
    end
  end

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  assign sclk_rise   = sclk_s2 & ~sclk_s3;
  assign sclk_fall   = ~sclk_s2 & sclk_s3;
  assign lead_edge   = cpol_l ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_l ? sclk_rise : sclk_fall;
  assign sample_edge = frame_active & (cpha_l ? trail_edge : lead_edge);
  assign shift_edge  = frame_active & (cpha_l ? lead_edge : trail_edge);

  // Receive path
  logic word_done, rx_accept, rx_store;
  assign rx_next   = lsb_l ? {mosi_s2, rx_sr[DATA_WIDTH-1:1]}
                           : {rx_sr[DATA_WIDTH-2:0], mosi_s2};
  assign word_done = sample_edge && (bit_cnt == LAST_BIT);
  assign rx_accept = rx_valid && rx_ready;
  // A pending word being accepted this cycle frees the slot for the new one.
  assign rx_store  = word_done && (!rx_valid || rx_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else if (!frame_active) begin
      bit_cnt <= '0;          // partial word from a dropped frame is discarded
    end else if (sample_edge) begin
      rx_sr   <= rx_next;
      bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (rx_store) begin
      rx_data  <= rx_next;
      rx_valid <= 1'b1;
    end else if (rx_accept) begin
      rx_valid <= 1'b0;
    end
  end

  // Transmit path. With cpha=0 the first bit must be on miso before the first
  // edge, so the word is loaded at frame start; with cpha=1 it loads on the
  // first shift edge. Every shift edge at a word boundary loads the next word.
  logic tx_load, tx_shift, tx_accept;
  assign tx_load   = (frame_start && !cpha) || (shift_edge && bit_cnt == '0);
  assign tx_shift  = shift_edge && (bit_cnt != '0);
  assign tx_accept = tx_valid && !hold_full;
  assign tx_ready  = !hold_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_sr     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      if (tx_load)
        tx_sr <= hold_full ? hold_data : TX_IDLE;
      else if (tx_shift)
        tx_sr <= lsb_l ? (tx_sr >> 1) : (tx_sr << 1);

      if (tx_accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (tx_load) begin
        hold_full <= 1'b0;
      end
    end
  end

  assign miso = frame_active ? (lsb_l ? tx_sr[0] : tx_sr[DATA_WIDTH-1]) : 1'b0;

`ifdef SPI_SLAVE_STREAM_STATUS_EN
  logic underrun_q, overrun_q;

  // Clear at frame start first so an event in that same cycle still sticks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (frame_start) begin
        underrun_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (tx_load && !hold_full)
        underrun_q <= 1'b1;
      if (word_done && rx_valid && !rx_ready)
        overrun_q <= 1'b1;
    end
  end

  assign tx_underrun = underrun_q;
  assign rx_overrun  = overrun_q;
`else
  assign tx_underrun = 1'b0;
  assign rx_overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// tb/tb_spi_slave_stream.sv - self-checking bench for spi_slave_stream
module tb_spi_slave_stream;

  localparam int DW       = 8;
  localparam bit CE_LEVEL = 1'b0;
  localparam int HALF     = 8;
`ifdef SPI_SLAVE_STREAM_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic          clock, reset;
  logic          cpol, cpha, lsb_first;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, rx_ready;
  logic          frame_active, tx_underrun, rx_overrun;
  logic          sclk, ce, mosi, miso, miso_oe;

  spi_slave_stream #(.DATA_WIDTH(DW), .CE_LEVEL(CE_LEVEL), .TX_IDLE(8'hFF)) dut (
    .clock(clock), .reset(reset),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_active(frame_active), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun),
    .sclk(sclk), .ce(ce), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] exp_miso[$];
  logic [DW-1:0] m_tx[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Producer: offers the head of tx_q; pops once the DUT has taken it.
  initial begin
    bit acc;
    acc      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clock);
      if (acc) void'(tx_q.pop_front());
      if (tx_q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = tx_q[0];
      end else begin
        tx_valid = 1'b0;
      end
      acc = tx_valid && tx_ready;
    end
  end

  // Consumer scoreboard: every rx handshake must match the next expected word.
  initial begin
    forever begin
      @(negedge clock);
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() > 0) begin
          check("rx_word", rx_data, exp_rx.pop_front());
        end else begin
          tests++;
          fails++;
          $error("FAIL rx_unexpected: observed 0x%0h expected no word", rx_data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // SPI master: nbits bits from m_tx, miso words compared against exp_miso.
  task automatic spi_frame(input bit pol, input bit pha, input bit lsb,
                           input int nbits, input bit chk);
    logic [DW-1:0] got;
    logic [DW-1:0] word;
    int idx;
    cpol = pol; cpha = pha; lsb_first = lsb; sclk = pol; mosi = 1'b0;
    repeat (HALF) @(negedge clock);
    ce = CE_LEVEL;
    repeat (HALF) @(negedge clock);
    got = '0;
    for (int b = 0; b < nbits; b++) begin
      idx  = lsb ? (b % DW) : (DW - 1 - (b % DW));
      word = m_tx[b / DW];
      if (!pha) begin
        mosi = word[idx];
        repeat (HALF) @(negedge clock);
        got[idx] = miso;
        sclk = ~pol;
        repeat (HALF) @(negedge clock);
        sclk = pol;
      end else begin
        sclk = ~pol;
        mosi = word[idx];
        repeat (HALF) @(negedge clock);
        sclk = pol;
        got[idx] = miso;
        repeat (HALF) @(negedge clock);
      end
      if ((b % DW) == DW - 1 && chk)
        check("miso_word", got, exp_miso.pop_front());
    end
    repeat (HALF) @(negedge clock);
    ce = ~CE_LEVEL;
    repeat (4) @(posedge clock);
    #1 check("frame_end_inactive", frame_active, 1'b0);
    repeat (HALF) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; ce = ~CE_LEVEL; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; rx_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_frame_active", frame_active, 1'b0);
    check("rst_flags", {tx_underrun, rx_overrun}, 2'b00);
    @(negedge clock) reset = 1'b0;
    repeat (5) @(negedge clock);

    // Mode 0, MSB first: preloaded 0xA5 out, 0x3C in.
    tx_q.push_back(8'hA5);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 check("tx_ready_after_accept", tx_ready, 1'b0);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    m_tx[0] = 8'h3C;
    spi_frame(1'b0, 1'b0, 1'b0, 8, 1'b1);
    check("m0_rx_count", exp_rx.size(), 0);
    check("m0_tx_ready", tx_ready, 1'b1);

    // Mode 3, LSB first, three words each way.
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
    repeat (4) @(negedge clock);
    exp_miso.push_back(8'h01); exp_miso.push_back(8'h02); exp_miso.push_back(8'h03);
    m_tx[0] = 8'h81; m_tx[1] = 8'h42; m_tx[2] = 8'h24;
    exp_rx.push_back(8'h81); exp_rx.push_back(8'h42); exp_rx.push_back(8'h24);
    spi_frame(1'b1, 1'b1, 1'b1, 24, 1'b1);
    check("m3_rx_count", exp_rx.size(), 0);
    check("m3_tx_drained", tx_q.size(), 0);
    check("m3_no_underrun", tx_underrun, 1'b0);

    // Mode 1 with nothing to send: idle word and underrun.
    exp_miso.push_back(8'hFF);
    m_tx[0] = 8'h5A;
    exp_rx.push_back(8'h5A);
    spi_frame(1'b0, 1'b1, 1'b0, 8, 1'b1);
    check("m1_underrun", tx_underrun, STATUS_EN);
    check("m1_rx_count", exp_rx.size(), 0);

    // Overrun: consumer stalled across a two-word frame.
    @(posedge clock);
    #1 rx_ready = 1'b0;
    m_tx[0] = 8'h11; m_tx[1] = 8'h22;
    exp_rx.push_back(8'h11);
    spi_frame(1'b0, 1'b0, 1'b0, 16, 1'b0);
    check("ovr_rx_data", rx_data, 8'h11);
    check("ovr_rx_valid", rx_valid, 1'b1);
    check("ovr_flag", rx_overrun, STATUS_EN);
    @(posedge clock);
    #1 rx_ready = 1'b1;
    repeat (20) @(negedge clock);
    check("ovr_rx_valid_after", rx_valid, 1'b0);
    check("ovr_rx_count", exp_rx.size(), 0);

    // Partial word: CE dropped after 5 bits.
    m_tx[0] = 8'hFF;
    spi_frame(1'b0, 1'b0, 1'b0, 5, 1'b0);
    check("partial_rx_valid", rx_valid, 1'b0);
    tx_q.push_back(8'h96);
    repeat (4) @(negedge clock);
    exp_miso.push_back(8'h96);
    m_tx[0] = 8'hC3;
    exp_rx.push_back(8'hC3);
    spi_frame(1'b1, 1'b0, 1'b0, 8, 1'b1);
    check("m2_rx_count", exp_rx.size(), 0);

    // Reset mid-word, released with CE still asserted.
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sclk = 1'b0;
    ce = CE_LEVEL;
    repeat (HALF) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      mosi = 1'b1;
      sclk = ~sclk;
      repeat (HALF) @(negedge clock);
    end
    check("mid_frame_active", frame_active, 1'b1);
    reset = 1'b1;
    #1;
    check("arst_frame_active", frame_active, 1'b0);
    check("arst_miso_oe", miso_oe, 1'b0);
    check("arst_miso", miso, 1'b0);
    check("arst_tx_ready", tx_ready, 1'b1);
    check("arst_rx_valid", rx_valid, 1'b0);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_flags", {tx_underrun, rx_overrun}, 2'b00);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("post_rst_idle", frame_active, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sclk = ~sclk;
      repeat (HALF) @(negedge clock);
    end
    check("post_rst_still_idle", frame_active, 1'b0);
    check("post_rst_no_rx", rx_valid, 1'b0);
    ce = ~CE_LEVEL;
    repeat (HALF) @(negedge clock);
    exp_miso.push_back(8'hFF);
    m_tx[0] = 8'h7E;
    exp_rx.push_back(8'h7E);
    spi_frame(1'b0, 1'b0, 1'b0, 8, 1'b1);
    check("recover_rx_count", exp_rx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
